// File: rtl/lsu_stall4mem.sv
// Load/store unit that stalls the core while it runs one access at a time against a
// single-ported data memory. Misaligned accesses that cross a bus-word boundary are split
// into two beats; load data is reassembled and sign/zero-extended before the response.
//
// Ports:
//   clk, rst                  clock and asynchronous active-high reset
//   req_*                     core request (captured only in the idle state)
//   rsp_valid_o/rdata/err     one-cycle completion pulse with extended load data / error flag
//   dmem_addr/wdata/wstrb     NB-aligned beat address, lane-positioned data, byte enables
//   dmem_read_o/write_o       beat request, held until dmem_ready_i
//   dmem_rdata, dmem_ready_i  read data and beat completion
module lsu_stall4mem #(
  parameter int unsigned ADDR_WIDTH    = 32,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter bit          MISALIGNED_EN = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic                    req_write_i,
  input  logic [1:0]              req_size_i,
  input  logic                    req_unsigned_i,
  input  logic [ADDR_WIDTH-1:0]   req_addr_i,
  input  logic [DATA_WIDTH-1:0]   req_wdata_i,
  output logic                    rsp_valid_o,
  output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
  output logic                    rsp_err_o,
  output logic [ADDR_WIDTH-1:0]   dmem_addr,
  output logic [DATA_WIDTH-1:0]   dmem_wdata,
  output logic [DATA_WIDTH/8-1:0] dmem_wstrb,
  output logic                    dmem_write_o,
  output logic                    dmem_read_o,
  input  logic [DATA_WIDTH-1:0]   dmem_rdata,
  input  logic                    dmem_ready_i
);

  localparam int unsigned NB   = DATA_WIDTH / 8;
  localparam int unsigned OffW = $clog2(NB);

  typedef enum logic [1:0] {StIdle, StAcc1, StAcc2, StResp} state_e;

  state_e                  state_q, state_d;
  logic                    write_q, write_d;
  logic [1:0]              size_q, size_d;
  logic                    uns_q, uns_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic                    err_q, err_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;

  // Request classification on the raw inputs, used only at capture time.
  logic [3:0] req_nbytes;
  logic       req_misaligned;
  logic       req_err;

  assign req_nbytes     = 4'd1 << req_size_i;
  // Low three address bits masked by (size-1); size 3 yields mask 3'b111.
  assign req_misaligned = |(req_addr_i[2:0] & (req_nbytes[2:0] - 3'd1));
  assign req_err        = ((req_size_i == 2'd3) && (DATA_WIDTH == 32)) ||
                          (!MISALIGNED_EN && req_misaligned);

  // Beat geometry derived from the captured request.
  logic [OffW-1:0]         off;
  logic [3:0]              nbytes_q;
  logic [4:0]              span;
  logic                    split;
  logic [NB-1:0]           size_mask;
  logic [2*NB-1:0]         strb_full;
  logic [2*DATA_WIDTH-1:0] wdata_full;
  logic [ADDR_WIDTH-1:0]   beat_addr;
  logic [DATA_WIDTH-1:0]   rd_lo;
  logic [2*DATA_WIDTH-1:0] rd_hi_full;
  logic [DATA_WIDTH-1:0]   load_ext;

  assign off        = addr_q[OffW-1:0];
  assign nbytes_q   = 4'd1 << size_q;
  assign span       = 5'(off) + 5'(nbytes_q);
  assign split      = (span > 5'(NB));
  assign beat_addr  = {addr_q[ADDR_WIDTH-1:OffW], {OffW{1'b0}}};

  always_comb begin
    size_mask = '0;
    for (int i = 0; i < NB; i++) begin
      size_mask[i] = (5'(i) < 5'(nbytes_q));
    end
  end

  // Shift the access into a double-width window: low half is beat 1, high half is beat 2.
  assign strb_full  = {{NB{1'b0}}, size_mask} << off;
  assign wdata_full = {{DATA_WIDTH{1'b0}}, wdata_q} << {off, 3'b000};

  // Beat 1 contributes its upper bytes at the bottom; beat 2 its lower bytes above them.
  assign rd_lo      = dmem_rdata >> {off, 3'b000};
  assign rd_hi_full = {dmem_rdata, {DATA_WIDTH{1'b0}}} >> {off, 3'b000};

  // Truncate to the access size, then sign- or zero-extend.
  always_comb begin
    int unsigned nbits;
    logic        fill;
    nbits = 32'(8) << size_q;
    if (nbits > DATA_WIDTH) begin
      nbits = DATA_WIDTH;
    end
    fill     = ~uns_q & rdata_q[nbits-1];
    load_ext = '0;
    for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
      load_ext[i] = (i < nbits) ? rdata_q[i] : fill;
    end
  end

  always_comb begin
    state_d      = state_q;
    write_d      = write_q;
    size_d       = size_q;
    uns_d        = uns_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    err_d        = err_q;
    rdata_d      = rdata_q;
    req_ready_o  = 1'b0;
    rsp_valid_o  = 1'b0;
    rsp_err_o    = 1'b0;
    rsp_rdata_o  = '0;
    dmem_addr    = '0;
    dmem_wdata   = '0;
    dmem_wstrb   = '0;
    dmem_read_o  = 1'b0;
    dmem_write_o = 1'b0;

    unique case (state_q)
      StIdle: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          write_d = req_write_i;
          size_d  = req_size_i;
          uns_d   = req_unsigned_i;
          addr_d  = req_addr_i;
          wdata_d = req_wdata_i;
          err_d   = req_err;
          rdata_d = '0;
          state_d = req_err ? StResp : StAcc1;
        end
      end
      StAcc1: begin
        dmem_addr    = beat_addr;
        dmem_wdata   = wdata_full[DATA_WIDTH-1:0];
        // Byte enables qualify writes only; read beats always return the full word.
        dmem_wstrb   = write_q ? strb_full[NB-1:0] : '0;
        dmem_read_o  = ~write_q;
        dmem_write_o = write_q;
        if (dmem_ready_i) begin
          if (!write_q) begin
            rdata_d = rd_lo;
          end
          state_d = split ? StAcc2 : StResp;
        end
      end
      StAcc2: begin
        dmem_addr    = beat_addr + ADDR_WIDTH'(NB);
        dmem_wdata   = wdata_full[2*DATA_WIDTH-1:DATA_WIDTH];
        dmem_wstrb   = write_q ? strb_full[2*NB-1:NB] : '0;
        dmem_read_o  = ~write_q;
        dmem_write_o = write_q;
        if (dmem_ready_i) begin
          if (!write_q) begin
            rdata_d = rdata_q | rd_hi_full[DATA_WIDTH-1:0];
          end
          state_d = StResp;
        end
      end
      StResp: begin
        rsp_valid_o = 1'b1;
        rsp_err_o   = err_q;
        rsp_rdata_o = (write_q || err_q) ? '0 : load_ext;
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      write_q <= 1'b0;
      size_q  <= 2'd0;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      write_q <= write_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

endmodule

// File: tb/tb_lsu_stall4mem.sv
// Bench for lsu_stall4mem: a byte-array memory answers beats with programmable wait states;
// results are compared against a byte-level model of loads and stores.
module tb_lsu_stall4mem;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid_a, req_valid_b, req_write, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata, dmem_rdata;
  logic        dmem_ready;

  logic        a_ready, a_rv, a_err, a_wr, a_rd;
  logic [31:0] a_rdata, a_daddr, a_dwdata;
  logic [3:0]  a_wstrb;
  logic        b_ready, b_rv, b_err, b_wr, b_rd;
  logic [31:0] b_rdata, b_daddr, b_dwdata;
  logic [3:0]  b_wstrb;

  always #5 clk = ~clk;

  lsu_stall4mem #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MISALIGNED_EN(1'b1)) u_dut (
    .clk(clk), .rst(rst), .req_valid_i(req_valid_a), .req_ready_o(a_ready),
    .req_write_i(req_write), .req_size_i(req_size), .req_unsigned_i(req_unsigned),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .rsp_valid_o(a_rv),
    .rsp_rdata_o(a_rdata), .rsp_err_o(a_err), .dmem_addr(a_daddr), .dmem_wdata(a_dwdata),
    .dmem_wstrb(a_wstrb), .dmem_write_o(a_wr), .dmem_read_o(a_rd),
    .dmem_rdata(dmem_rdata), .dmem_ready_i(dmem_ready)
  );

  lsu_stall4mem #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MISALIGNED_EN(1'b0)) u_dut_strict (
    .clk(clk), .rst(rst), .req_valid_i(req_valid_b), .req_ready_o(b_ready),
    .req_write_i(req_write), .req_size_i(req_size), .req_unsigned_i(req_unsigned),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .rsp_valid_o(b_rv),
    .rsp_rdata_o(b_rdata), .rsp_err_o(b_err), .dmem_addr(b_daddr), .dmem_wdata(b_dwdata),
    .dmem_wstrb(b_wstrb), .dmem_write_o(b_wr), .dmem_read_o(b_rd),
    .dmem_rdata(dmem_rdata), .dmem_ready_i(dmem_ready)
  );

  int total = 0;
  int bad   = 0;

  logic [7:0] mem [256];
  logic [7:0] mem_before [256];

  // Observations of the most recent run_access.
  bit          obs_ready_start, obs_rv_start, obs_got, obs_err;
  int          obs_rsp_cyc, obs_nbeats;
  logic [31:0] obs_rdata;
  logic [31:0] bt_addr [4];
  logic [31:0] bt_wdata [4];
  logic [3:0]  bt_wstrb [4];
  logic        bt_wr [4];
  logic        bt_rd [4];

  // Issue one request and act as the memory until the response; w1/w2 are wait cycles per beat.
  task automatic run_access(input bit sel, input bit wr, input logic [1:0] sz, input bit uns,
                            input logic [31:0] ad, input logic [31:0] wd,
                            input int w1, input int w2);
    int          cyc, wcnt;
    bit          done;
    logic        rv, er, rd_o, wr_o;
    logic [31:0] rdat, da, dwd;
    logic [3:0]  ws;
    logic [7:0]  idx;
    obs_nbeats = 0; obs_got = 0; obs_err = 0; obs_rsp_cyc = -1; obs_rdata = '0;
    for (int i = 0; i < 4; i++) begin
      bt_addr[i] = '0; bt_wdata[i] = '0; bt_wstrb[i] = '0; bt_wr[i] = 0; bt_rd[i] = 0;
    end
    @(negedge clk);
    obs_ready_start = sel ? b_ready : a_ready;
    obs_rv_start    = sel ? b_rv : a_rv;
    req_write = wr; req_size = sz; req_unsigned = uns; req_addr = ad; req_wdata = wd;
    if (sel) req_valid_b = 1'b1;
    else     req_valid_a = 1'b1;
    @(negedge clk);
    req_valid_a = 1'b0; req_valid_b = 1'b0;
    req_addr = $urandom; req_wdata = $urandom; req_size = 2'($urandom);
    cyc = 1; wcnt = 0; done = 0;
    while (!done && cyc < 60) begin
      if (sel) begin
        rv = b_rv; er = b_err; rdat = b_rdata; rd_o = b_rd; wr_o = b_wr;
        da = b_daddr; dwd = b_dwdata; ws = b_wstrb;
      end else begin
        rv = a_rv; er = a_err; rdat = a_rdata; rd_o = a_rd; wr_o = a_wr;
        da = a_daddr; dwd = a_dwdata; ws = a_wstrb;
      end
      dmem_ready = 1'b0;
      dmem_rdata = $urandom;
      if (rv) begin
        obs_got = 1; obs_rsp_cyc = cyc; obs_rdata = rdat; obs_err = er; done = 1;
      end else if (rd_o || wr_o) begin
        if (wcnt < ((obs_nbeats == 0) ? w1 : w2)) begin
          wcnt++;
        end else begin
          dmem_ready = 1'b1;
          for (int j = 0; j < 4; j++) begin
            idx = da[7:0] + 8'(j);
            dmem_rdata[8*j +: 8] = mem[idx];
          end
          if (wr_o) begin
            for (int j = 0; j < 4; j++) begin
              idx = da[7:0] + 8'(j);
              if (ws[j]) mem[idx] = dwd[8*j +: 8];
            end
          end
          if (obs_nbeats < 4) begin
            bt_addr[obs_nbeats] = da; bt_wdata[obs_nbeats] = dwd; bt_wstrb[obs_nbeats] = ws;
            bt_wr[obs_nbeats] = wr_o; bt_rd[obs_nbeats] = rd_o;
          end
          obs_nbeats++;
          wcnt = 0;
        end
      end
      if (!done) begin
        @(negedge clk);
        cyc++;
      end
    end
    dmem_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    total++; if (a_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", a_ready); end
    total++; if (a_rv !== 1'b0 || a_err !== 1'b0) begin bad++; $display("FAIL reset_rsp got=%b%b want=00", a_rv, a_err); end
    total++; if (a_rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h want=0", a_rdata); end
    total++; if (a_rd !== 1'b0 || a_wr !== 1'b0) begin bad++; $display("FAIL reset_strobes got=%b%b want=00", a_rd, a_wr); end
    total++; if (a_daddr !== 32'h0 || a_dwdata !== 32'h0 || a_wstrb !== 4'h0) begin
      bad++; $display("FAIL reset_dmem got addr=%h wdata=%h wstrb=%h want 0", a_daddr, a_dwdata, a_wstrb);
    end
    @(posedge clk); #2 rst = 1'b0;
  endtask

  task automatic test_lw_wait();
    mem[8'h00] = 8'h01; mem[8'h01] = 8'h00; mem[8'h02] = 8'h00; mem[8'h03] = 8'h80;
    run_access(0, 0, 2'd2, 0, 32'h100, 32'h0, 2, 0);
    total++; if (obs_ready_start !== 1'b1) begin bad++; $display("FAIL lw_ready got=%b want=1", obs_ready_start); end
    total++; if (obs_rsp_cyc != 4) begin bad++; $display("FAIL lw_latency got=%0d want=4", obs_rsp_cyc); end
    total++; if (obs_rdata !== 32'h8000_0001) begin bad++; $display("FAIL lw_rdata got=%h want=80000001", obs_rdata); end
    total++; if (obs_nbeats != 1 || bt_addr[0] !== 32'h100 || bt_wstrb[0] !== 4'h0 || bt_rd[0] !== 1'b1) begin
      bad++; $display("FAIL lw_beat got n=%0d addr=%h wstrb=%h rd=%b want 1/100/0/1", obs_nbeats, bt_addr[0], bt_wstrb[0], bt_rd[0]);
    end
  endtask

  task automatic test_lh_sign();
    mem[8'h02] = 8'hEE; mem[8'h03] = 8'hFF;
    run_access(0, 0, 2'd1, 0, 32'h102, 32'h0, 0, 0);
    total++; if (obs_rdata !== 32'hFFFF_FFEE || obs_rsp_cyc != 2) begin
      bad++; $display("FAIL lh_signed got=%h cyc=%0d want=ffffffee cyc=2", obs_rdata, obs_rsp_cyc);
    end
    run_access(0, 0, 2'd1, 1, 32'h102, 32'h0, 1, 0);
    total++; if (obs_rdata !== 32'h0000_FFEE || obs_rsp_cyc != 3) begin
      bad++; $display("FAIL lhu got=%h cyc=%0d want=0000ffee cyc=3", obs_rdata, obs_rsp_cyc);
    end
  endtask

  task automatic test_split_store();
    run_access(0, 1, 2'd2, 0, 32'h103, 32'hAABB_CCDD, 0, 0);
    total++; if (obs_nbeats != 2 || obs_rsp_cyc != 3) begin
      bad++; $display("FAIL sw_split_shape got n=%0d cyc=%0d want n=2 cyc=3", obs_nbeats, obs_rsp_cyc);
    end
    total++; if (bt_addr[0] !== 32'h100 || bt_wstrb[0] !== 4'b1000 || bt_wdata[0] !== 32'hDD00_0000 || bt_wr[0] !== 1'b1) begin
      bad++; $display("FAIL sw_beat1 got %h/%b/%h want 100/1000/dd000000", bt_addr[0], bt_wstrb[0], bt_wdata[0]);
    end
    total++; if (bt_addr[1] !== 32'h104 || bt_wstrb[1] !== 4'b0111 || bt_wdata[1] !== 32'h00AA_BBCC || bt_wr[1] !== 1'b1) begin
      bad++; $display("FAIL sw_beat2 got %h/%b/%h want 104/0111/00aabbcc", bt_addr[1], bt_wstrb[1], bt_wdata[1]);
    end
    total++; if (obs_rdata !== 32'h0 || obs_err !== 1'b0) begin
      bad++; $display("FAIL sw_rsp got rdata=%h err=%b want 0/0", obs_rdata, obs_err);
    end
  endtask

  task automatic test_wrap();
    mem[8'hFE] = 8'h11; mem[8'hFF] = 8'h22; mem[8'h00] = 8'h33; mem[8'h01] = 8'h44;
    run_access(0, 0, 2'd2, 0, 32'hFFFF_FFFE, 32'h0, 1, 0);
    total++; if (obs_nbeats != 2 || bt_addr[0] !== 32'hFFFF_FFFC || bt_addr[1] !== 32'h0) begin
      bad++; $display("FAIL wrap_addr got n=%0d %h %h want 2 fffffffc 0", obs_nbeats, bt_addr[0], bt_addr[1]);
    end
    total++; if (obs_rdata !== 32'h4433_2211 || obs_rsp_cyc != 4) begin
      bad++; $display("FAIL wrap_data got=%h cyc=%0d want=44332211 cyc=4", obs_rdata, obs_rsp_cyc);
    end
  endtask

  task automatic test_errors();
    run_access(0, 0, 2'd3, 0, 32'h100, 32'h0, 0, 0);
    total++; if (obs_err !== 1'b1 || obs_rsp_cyc != 1 || obs_nbeats != 0 || obs_rdata !== 32'h0) begin
      bad++; $display("FAIL err_dword got err=%b cyc=%0d n=%0d rdata=%h want 1/1/0/0", obs_err, obs_rsp_cyc, obs_nbeats, obs_rdata);
    end
    run_access(1, 0, 2'd1, 0, 32'h101, 32'h0, 0, 0);
    total++; if (obs_err !== 1'b1 || obs_rsp_cyc != 1 || obs_nbeats != 0 || obs_rdata !== 32'h0) begin
      bad++; $display("FAIL err_misaligned got err=%b cyc=%0d n=%0d rdata=%h want 1/1/0/0", obs_err, obs_rsp_cyc, obs_nbeats, obs_rdata);
    end
    mem[8'h04] = 8'h78; mem[8'h05] = 8'h56; mem[8'h06] = 8'h34; mem[8'h07] = 8'h12;
    run_access(1, 0, 2'd2, 0, 32'h104, 32'h0, 0, 0);
    total++; if (obs_err !== 1'b0 || obs_rsp_cyc != 2 || obs_rdata !== 32'h1234_5678) begin
      bad++; $display("FAIL strict_aligned got err=%b cyc=%0d rdata=%h want 0/2/12345678", obs_err, obs_rsp_cyc, obs_rdata);
    end
  endtask

  task automatic test_reset_mid();
    int          seen;
    logic [31:0] want;
    @(negedge clk);
    req_write = 0; req_size = 2'd2; req_unsigned = 0; req_addr = 32'h100; req_valid_a = 1'b1;
    dmem_ready = 1'b0;
    @(negedge clk); req_valid_a = 1'b0;
    @(negedge clk);
    total++; if (a_rd !== 1'b1) begin bad++; $display("FAIL mid_read_before got=%b want=1", a_rd); end
    #2 rst = 1'b1;
    #1;
    total++; if (a_rd !== 1'b0 || a_ready !== 1'b1 || a_rv !== 1'b0) begin
      bad++; $display("FAIL mid_abandon got rd=%b ready=%b rv=%b want 0/1/0", a_rd, a_ready, a_rv);
    end
    @(posedge clk); #2 rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (a_rv || a_rd) seen++;
    end
    total++; if (seen != 0) begin bad++; $display("FAIL mid_no_rsp got=%0d want=0", seen); end
    @(posedge clk); #2 rst = 1'b1; #2 rst = 1'b0;
    want = {mem[8'h03], mem[8'h02], mem[8'h01], mem[8'h00]};
    run_access(0, 0, 2'd2, 0, 32'h100, 32'h0, 0, 0);
    total++; if (obs_ready_start !== 1'b1 || obs_rsp_cyc != 2 || obs_rdata !== want) begin
      bad++; $display("FAIL post_reset_lw got ready=%b cyc=%0d rdata=%h want 1/2/%h", obs_ready_start, obs_rsp_cyc, obs_rdata, want);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 60; n++) begin
      bit          wr, uns, err, split;
      logic [1:0]  sz;
      logic [31:0] ad, wd, val, want_rd, b1;
      int          off, nb, w1, w2, nbeats, cyc, diffs;
      logic [7:0]  want_mem [256];
      wr = 1'($urandom); uns = 1'($urandom); sz = 2'($urandom);
      ad = 32'h100 + $urandom_range(0, 40); wd = $urandom;
      w1 = $urandom_range(0, 2); w2 = $urandom_range(0, 2);
      off = int'(ad % 4); nb = 1 << sz;
      err = (sz == 2'd3);
      split = !err && (off + nb > 4);
      nbeats = err ? 0 : (split ? 2 : 1);
      cyc = err ? 1 : 1 + nbeats + w1 + (split ? w2 : 0);
      for (int i = 0; i < 256; i++) begin mem_before[i] = mem[i]; want_mem[i] = mem[i]; end
      val = '0;
      for (int i = 0; i < nb && i < 4; i++) begin
        val = val | (32'(mem_before[8'(ad + i)]) << (8 * i));
        if (wr && !err) want_mem[8'(ad + i)] = wd[8*i +: 8];
      end
      if (!uns && nb < 4 && val[8*nb-1]) val = val | (32'hFFFF_FFFF << (8 * nb));
      want_rd = (wr || err) ? 32'h0 : val;
      b1 = ad & 32'hFFFF_FFFC;
      run_access(0, wr, sz, uns, ad, wd, w1, w2);
      total++; if (obs_ready_start !== 1'b1 || obs_rv_start !== 1'b0) begin
        bad++; $display("FAIL rnd%0d_accept got ready=%b rv=%b want 1/0", n, obs_ready_start, obs_rv_start);
      end
      total++; if (obs_got !== 1'b1 || obs_rsp_cyc != cyc || obs_err !== err) begin
        bad++; $display("FAIL rnd%0d_rsp got valid=%b cyc=%0d err=%b want 1/%0d/%b", n, obs_got, obs_rsp_cyc, obs_err, cyc, err);
      end
      total++; if (obs_rdata !== want_rd) begin
        bad++; $display("FAIL rnd%0d_rdata got=%h want=%h (sz=%0d addr=%h uns=%b)", n, obs_rdata, want_rd, sz, ad, uns);
      end
      total++; if (obs_nbeats != nbeats || (nbeats > 0 && bt_addr[0] !== b1) || (nbeats > 1 && bt_addr[1] !== b1 + 32'd4)) begin
        bad++; $display("FAIL rnd%0d_beats got n=%0d %h %h want n=%0d %h", n, obs_nbeats, bt_addr[0], bt_addr[1], nbeats, b1);
      end
      for (int k = 0; k < nbeats; k++) begin
        total++; if (bt_wr[k] !== wr || bt_rd[k] !== !wr || (!wr && bt_wstrb[k] !== 4'h0)) begin
          bad++; $display("FAIL rnd%0d_dir%0d got wr=%b rd=%b wstrb=%h want wr=%b", n, k, bt_wr[k], bt_rd[k], bt_wstrb[k], wr);
        end
      end
      diffs = 0;
      for (int i = 0; i < 256; i++) if (mem[i] !== want_mem[i]) diffs++;
      total++; if (diffs != 0) begin
        bad++; $display("FAIL rnd%0d_mem got %0d differing bytes want 0 (addr=%h sz=%0d)", n, diffs, ad, sz);
      end
    end
  endtask

  initial begin
    rst = 1'b1; req_valid_a = 0; req_valid_b = 0; req_write = 0; req_size = 0;
    req_unsigned = 0; req_addr = 0; req_wdata = 0; dmem_rdata = 0; dmem_ready = 0;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    test_reset();
    test_lw_wait();
    test_lh_sign();
    test_split_store();
    test_wrap();
    test_errors();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
